// File: rtl/tjmono_hit_assembler.sv
// TJ-Monopix hit assembler: pops RX FIFO words, rebuilds 4-word hit records and
// hands them out over valid/ready. Optional ToT filter: define TJMONO_HIT_TOT_FILTER_EN.
module tjmono_hit_assembler #(
  parameter logic [1:0]  IDENTIFIER = 2'b00,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             BUS_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             IN_EMPTY,
  input  logic [31:0]      IN_DATA,
  output logic             IN_READ,
  input  logic [5:0]       MIN_TOT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [5:0]       OUT_COL,
  output logic [8:0]       OUT_ROW,
  output logic [5:0]       OUT_LE,
  output logic [5:0]       OUT_TE,
  output logic [5:0]       OUT_TOT,
  output logic             OUT_NOISE,
  output logic [51:0]      OUT_TOKEN_TS,
  output logic [31:0]      OUT_TOKEN_CNT,
  output logic [CNT_W-1:0] SEQ_ERR_CNT,
  output logic [CNT_W-1:0] ID_ERR_CNT,
  output logic [31:0]      HIT_CNT
`ifdef TJMONO_HIT_TOT_FILTER_EN
  ,
  output logic [31:0]      TOT_DROP_CNT
`endif
);

  logic         rd_pending;
  logic [1:0]   exp_tag;
  logic [83:0]  asm_buf;

  logic [1:0]   word_id;
  logic [1:0]   word_tag;
  logic [27:0]  word_payload;
  logic [111:0] rec;
  logic [5:0]   rec_col;
  logic [8:0]   rec_row;
  logic [5:0]   rec_te;
  logic [5:0]   rec_le;
  logic         rec_noise;
  logic [51:0]  rec_ts;
  logic [31:0]  rec_cnt;
  logic [5:0]   rec_tot;
  logic         rec_drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign word_id      = IN_DATA[31:30];
  assign word_tag     = IN_DATA[29:28];
  assign word_payload = IN_DATA[27:0];

  // The tag3 payload completes the record straight from the bus, so slot 3 is never stored.
  assign rec       = {word_payload, asm_buf};
  assign rec_col   = rec[5:0];
  assign rec_row   = rec[14:6];
  assign rec_te    = rec[20:15];
  assign rec_le    = rec[26:21];
  assign rec_noise = rec[27];
  assign rec_ts    = rec[79:28];
  assign rec_cnt   = rec[111:80];
  assign rec_tot   = rec_te - rec_le;

`ifdef TJMONO_HIT_TOT_FILTER_EN
  assign rec_drop = (rec_tot < MIN_TOT);
`else
  logic unused_min_tot;
  assign unused_min_tot = ^MIN_TOT;
  assign rec_drop       = 1'b0;
`endif

  // One read in flight at a time, and never while a held record could be overwritten.
  assign IN_READ = !RST && EN && !IN_EMPTY && !rd_pending && (!OUT_VALID || OUT_READY);

  // NOTE: all state lives in one clocked block using non-blocking assignments only, so
  // later statements that overwrite earlier ones (e.g. valid clear vs. set) resolve by order.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      rd_pending    <= 1'b0;
      exp_tag       <= 2'd0;
      asm_buf       <= '0;
      OUT_VALID     <= 1'b0;
      OUT_COL       <= '0;
      OUT_ROW       <= '0;
      OUT_LE        <= '0;
      OUT_TE        <= '0;
      OUT_TOT       <= '0;
      OUT_NOISE     <= 1'b0;
      OUT_TOKEN_TS  <= '0;
      OUT_TOKEN_CNT <= '0;
      SEQ_ERR_CNT   <= '0;
      ID_ERR_CNT    <= '0;
      HIT_CNT       <= '0;
`ifdef TJMONO_HIT_TOT_FILTER_EN
      TOT_DROP_CNT  <= '0;
`endif
    end else begin
      rd_pending <= IN_READ;

      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
        HIT_CNT   <= HIT_CNT + 32'd1;
      end

      if (rd_pending) begin
        if (word_id != IDENTIFIER) begin
          ID_ERR_CNT <= sat_inc(ID_ERR_CNT);
          exp_tag    <= 2'd0;
          asm_buf    <= '0;
        end else if (word_tag == exp_tag) begin
          exp_tag <= exp_tag + 2'd1;
          case (word_tag)
            2'd0: asm_buf[27:0]  <= word_payload;
            2'd1: asm_buf[55:28] <= word_payload;
            2'd2: asm_buf[83:56] <= word_payload;
            default: begin
              // Output slot is guaranteed free here: the read was gated on it.
              if (rec_drop) begin
`ifdef TJMONO_HIT_TOT_FILTER_EN
                TOT_DROP_CNT <= TOT_DROP_CNT + 32'd1;
`endif
              end else begin
                OUT_VALID     <= 1'b1;
                OUT_COL       <= rec_col;
                OUT_ROW       <= rec_row;
                OUT_LE        <= rec_le;
                OUT_TE        <= rec_te;
                OUT_TOT       <= rec_tot;
                OUT_NOISE     <= rec_noise;
                OUT_TOKEN_TS  <= rec_ts;
                OUT_TOKEN_CNT <= rec_cnt;
              end
            end
          endcase
        end else begin
          SEQ_ERR_CNT <= sat_inc(SEQ_ERR_CNT);
          if (word_tag == 2'd0) begin
            asm_buf <= {56'd0, word_payload};
            exp_tag <= 2'd1;
          end else begin
            asm_buf <= '0;
            exp_tag <= 2'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tjmono_hit_assembler.sv
// Directed self-checking bench for tjmono_hit_assembler with a behavioural RX FIFO model.
// Compile with TJMONO_HIT_TOT_FILTER_EN defined to exercise the ToT filter.
module tb_tjmono_hit_assembler;

  logic        BUS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        IN_EMPTY;
  logic [31:0] IN_DATA = '0;
  logic        IN_READ;
  logic [5:0]  MIN_TOT = 6'd8;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [5:0]  OUT_COL;
  logic [8:0]  OUT_ROW;
  logic [5:0]  OUT_LE;
  logic [5:0]  OUT_TE;
  logic [5:0]  OUT_TOT;
  logic        OUT_NOISE;
  logic [51:0] OUT_TOKEN_TS;
  logic [31:0] OUT_TOKEN_CNT;
  logic [7:0]  SEQ_ERR_CNT;
  logic [7:0]  ID_ERR_CNT;
  logic [31:0] HIT_CNT;
`ifdef TJMONO_HIT_TOT_FILTER_EN
  logic [31:0] TOT_DROP_CNT;
`endif

  always #5 BUS_CLK = ~BUS_CLK;

  tjmono_hit_assembler #(.IDENTIFIER(2'b00), .CNT_W(8)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .EN(EN), .IN_EMPTY(IN_EMPTY), .IN_DATA(IN_DATA),
    .IN_READ(IN_READ), .MIN_TOT(MIN_TOT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_COL(OUT_COL), .OUT_ROW(OUT_ROW), .OUT_LE(OUT_LE), .OUT_TE(OUT_TE),
    .OUT_TOT(OUT_TOT), .OUT_NOISE(OUT_NOISE), .OUT_TOKEN_TS(OUT_TOKEN_TS),
    .OUT_TOKEN_CNT(OUT_TOKEN_CNT), .SEQ_ERR_CNT(SEQ_ERR_CNT), .ID_ERR_CNT(ID_ERR_CNT),
`ifdef TJMONO_HIT_TOT_FILTER_EN
    .TOT_DROP_CNT(TOT_DROP_CNT),
`endif
    .HIT_CNT(HIT_CNT)
  );

  // Upstream FIFO: data appears the cycle after IN_READ.
  logic [31:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  assign IN_EMPTY = (wr_ptr == rd_ptr);

  always @(posedge BUS_CLK) begin
    if (IN_READ && !IN_EMPTY) begin
      IN_DATA <= fifo_mem[rd_ptr % 1024];
      rd_ptr  <= rd_ptr + 1;
      rd_cnt  <= rd_cnt + 1;
    end
  end

  typedef struct {
    logic [5:0]  col;
    logic [8:0]  row;
    logic [5:0]  le;
    logic [5:0]  te;
    logic [5:0]  tot;
    logic        noise;
    logic [51:0] ts;
    logic [31:0] cnt;
  } rec_t;
  rec_t cap[$];

  // Handshakes are sampled mid-cycle, when both DUT outputs and bench inputs are settled.
  always @(negedge BUS_CLK) begin
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1)
      cap.push_back('{OUT_COL, OUT_ROW, OUT_LE, OUT_TE, OUT_TOT, OUT_NOISE,
                      OUT_TOKEN_TS, OUT_TOKEN_CNT});
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  function automatic logic [111:0] make_rec(input logic [5:0] col, input logic [8:0] row,
                                            input logic [5:0] le, input logic [5:0] te,
                                            input logic noise, input logic [51:0] ts,
                                            input logic [31:0] cnt);
    return {cnt, ts, noise, le, te, row, col};
  endfunction

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_tag(input logic [111:0] r, input int t);
    logic [27:0] p;
    p = r[28*t +: 28];
    push_word({2'b00, 2'(t), p});
  endtask

  task automatic push_group(input logic [111:0] r);
    for (int t = 0; t < 4; t++) push_tag(r, t);
  endtask

  task automatic wait_hits(input int n, input int budget, input string tag);
    int b = 0;
    while (cap.size() < n && b < budget) begin
      tick();
      b++;
    end
    check(tag, 64'(cap.size()), 64'(n));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int b = 0;
    while (rd_ptr != wr_ptr && b < budget) begin
      tick();
      b++;
    end
    check(tag, 64'(rd_ptr), 64'(wr_ptr));
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [111:0] g;
  int exp_hits;
  int rd0;
  int b;
  int stable_err;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_in_read", IN_READ, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_col", OUT_COL, 0);
    check("rst_out_ts", OUT_TOKEN_TS, 0);
    check("rst_hit_cnt", HIT_CNT, 0);
    check("rst_seq_err", SEQ_ERR_CNT, 0);
    check("rst_id_err", ID_ERR_CNT, 0);
    RST = 1'b0;
    EN  = 1'b1;
    tick();

    // One clean group
    push_group(make_rec(6'd5, 9'd300, 6'd10, 6'd25, 1'b0, 52'h123456789AB, 32'd7));
    wait_hits(1, 100, "g1_timeout");
    repeat (3) tick();
    check("g1_col", cap[0].col, 5);
    check("g1_row", cap[0].row, 300);
    check("g1_le", cap[0].le, 10);
    check("g1_te", cap[0].te, 25);
    check("g1_tot", cap[0].tot, 15);
    check("g1_noise", cap[0].noise, 0);
    check("g1_ts", cap[0].ts, 52'h123456789AB);
    check("g1_cnt", cap[0].cnt, 7);
    check("g1_hit_cnt", HIT_CNT, 1);
    check("g1_seq_err", SEQ_ERR_CNT, 0);
    check("g1_id_err", ID_ERR_CNT, 0);

    // Tags 0,1,3 then a full group: one sequence error, record from last four words
    g = make_rec(6'd63, 9'd511, 6'd0, 6'd0, 1'b1, 52'hFFFFF, 32'hDEAD);
    push_tag(g, 0); push_tag(g, 1); push_tag(g, 3);
    push_group(make_rec(6'd17, 9'd1, 6'd3, 6'd20, 1'b1, 52'hABC, 32'd99));
    wait_hits(2, 200, "g2_timeout");
    repeat (30) tick();
    check("g2_records", cap.size(), 2);
    check("g2_seq_err", SEQ_ERR_CNT, 1);
    check("g2_col", cap[1].col, 17);
    check("g2_row", cap[1].row, 1);
    check("g2_noise", cap[1].noise, 1);
    check("g2_tot", cap[1].tot, 17);
    check("g2_cnt", cap[1].cnt, 99);

    // Bad id inside a group, then a clean group
    g = make_rec(6'd1, 9'd2, 6'd3, 6'd4, 1'b0, 52'h1, 32'd1);
    push_tag(g, 0); push_tag(g, 1);
    push_word({2'b01, 2'd2, 28'h5A5A5A5});
    push_group(make_rec(6'd40, 9'd256, 6'd0, 6'd63, 1'b0, 52'h0, 32'hFFFFFFFF));
    wait_hits(3, 200, "g4_timeout");
    repeat (20) tick();
    check("g4_records", cap.size(), 3);
    check("g4_id_err", ID_ERR_CNT, 1);
    check("g4_seq_err", SEQ_ERR_CNT, 1);
    check("g4_col", cap[2].col, 40);
    check("g4_row", cap[2].row, 256);
    check("g4_tot", cap[2].tot, 63);
    check("g4_cnt", cap[2].cnt, 32'hFFFFFFFF);
    check("g4_hit_cnt", HIT_CNT, 3);

    // Back-to-back groups with the consumer stalled
    OUT_READY = 1'b0;
    push_group(make_rec(6'd11, 9'd100, 6'd5, 6'd50, 1'b0, 52'h55, 32'd1000));
    push_group(make_rec(6'd22, 9'd200, 6'd40, 6'd63, 1'b1, 52'h66, 32'd2000));
    b = 0;
    while (OUT_VALID !== 1'b1 && b < 100) begin
      tick();
      b++;
    end
    check("stall_valid", OUT_VALID, 1);
    rd0 = rd_cnt;
    stable_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (OUT_VALID !== 1'b1 || OUT_COL !== 6'd11 || OUT_ROW !== 9'd100 ||
          OUT_TOT !== 6'd45 || OUT_TOKEN_CNT !== 32'd1000)
        stable_err++;
      tick();
    end
    check("stall_hold_stable", stable_err, 0);
    check("stall_reads_le1", 64'((rd_cnt - rd0) <= 1), 1);
    check("stall_hit_cnt", HIT_CNT, 3);
    OUT_READY = 1'b1;
    wait_hits(5, 200, "b2b_timeout");
    repeat (3) tick();
    check("b2b_first_col", cap[3].col, 11);
    check("b2b_first_ts", cap[3].ts, 52'h55);
    check("b2b_second_col", cap[4].col, 22);
    check("b2b_second_tot", cap[4].tot, 23);
    check("b2b_hit_cnt", HIT_CNT, 5);

    // ToT wrap: le=60, te=2
    push_group(make_rec(6'd33, 9'd7, 6'd60, 6'd2, 1'b0, 52'h77, 32'd3));
`ifdef TJMONO_HIT_TOT_FILTER_EN
    repeat (40) tick();
    check("filter_no_record", cap.size(), 5);
    check("filter_drop_cnt", TOT_DROP_CNT, 1);
    check("filter_hit_cnt", HIT_CNT, 5);
    exp_hits = 5;
`else
    wait_hits(6, 100, "wrap_timeout");
    repeat (3) tick();
    check("wrap_le", cap[5].le, 60);
    check("wrap_te", cap[5].te, 2);
    check("wrap_tot", cap[5].tot, 6);
    check("wrap_hit_cnt", HIT_CNT, 6);
    exp_hits = 6;
`endif

    // 300 bad-id words saturate the id error counter
    for (int i = 0; i < 300; i++) push_word({2'b10, 2'(i), 28'(i)});
    wait_drain(1000, "sat_drain");
    check("sat_id_err", ID_ERR_CNT, 255);
    check("sat_seq_err", SEQ_ERR_CNT, 1);

    // Reset after tag1 of a group, then a clean group
    g = make_rec(6'd9, 9'd9, 6'd9, 6'd9, 1'b1, 52'h9, 32'd9);
    push_tag(g, 0); push_tag(g, 1);
    wait_drain(100, "rst_mid_drain");
    RST = 1'b1;
    tick();
    check("rst_mid_out_valid", OUT_VALID, 0);
    check("rst_mid_out_col", OUT_COL, 0);
    check("rst_mid_out_cnt", OUT_TOKEN_CNT, 0);
    check("rst_mid_hit_cnt", HIT_CNT, 0);
    check("rst_mid_id_err", ID_ERR_CNT, 0);
    check("rst_mid_seq_err", SEQ_ERR_CNT, 0);
    check("rst_mid_in_read", IN_READ, 0);
    RST = 1'b0;
    tick();
    push_group(make_rec(6'd44, 9'd444, 6'd1, 6'd9, 1'b0, 52'hFEDCBA987654, 32'd55));
    wait_hits(exp_hits + 1, 100, "post_rst_timeout");
    repeat (3) tick();
    check("post_rst_col", cap[exp_hits].col, 44);
    check("post_rst_row", cap[exp_hits].row, 444);
    check("post_rst_tot", cap[exp_hits].tot, 8);
    check("post_rst_ts", cap[exp_hits].ts, 52'hFEDCBA987654);
    check("post_rst_hit_cnt", HIT_CNT, 1);
    check("post_rst_seq_err", SEQ_ERR_CNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
